ula_seq_ctrl: RTL and testbench

Multicycle sequencer that drives the 3-bit ULA datapath (adder/subtractor plus 4:1 output mux) from a valid/ready command stream. It owns the accumulator, carry and error flags. Each command goes through a fixed IDLE→EXEC→DONE sequence. The ULA stays a separate combinational instance: this block drives its a, b, subtrai and s inputs and samples its fi and cout outputs.

---
 rtl/ula_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ula_seq_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ula_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ula_seq_ctrl
// Purpose  : Multicycle sequencer for the W-bit ULA datapath (adder/subtractor
//            and 4:1 output mux). Accepts one valid/ready command at a time
//            and runs it through an IDLE -> EXEC -> DONE sequence. It owns
//            the accumulator and the carry flag. The ULA is a separate
//            combinational instance: this block drives a/b/subtrai/s and
//            samples fi/cout.
// Ports    : clk, rst        - clock (rising edge), synchronous active-high reset
//            cmd_valid/ready - command handshake (ready only in IDLE)
//            cmd_op          - 000 NOP, 001 LDA, 010 ADD, 011 SUB, 100 PASS,
//                              101..111 illegal
//            cmd_data        - operand
//            alu_a/b/sub/sel - drive to the ULA (a, b, subtrai, s)
//            alu_f/alu_cout  - result and carry from the ULA
//            acc, flag_c     - accumulator and carry of the last ADD/SUB
//            flag_n, flag_z  - sign and zero of acc (combinational)
//            res_valid, err  - completion pulse; err marks an illegal opcode
// Revision : 1.0 - initial release
// ============================================================================
module ula_seq_ctrl #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_data,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_sub,
  output logic [1:0]   alu_sel,
  input  logic [W-1:0] alu_f,
  input  logic         alu_cout,
  output logic [W-1:0] acc,
  output logic         flag_c,
  output logic         flag_n,
  output logic         flag_z,
  output logic         res_valid,
  output logic         err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] C_OP_NOP  = 3'b000;
  localparam logic [2:0] C_OP_LDA  = 3'b001;
  localparam logic [2:0] C_OP_ADD  = 3'b010;
  localparam logic [2:0] C_OP_SUB  = 3'b011;
  localparam logic [2:0] C_OP_PASS = 3'b100;

  localparam logic [1:0] C_SEL_A   = 2'b00;
  localparam logic [1:0] C_SEL_B   = 2'b01;
  localparam logic [1:0] C_SEL_SUM = 2'b10;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [2:0]   r_op;
  logic [W-1:0] r_opnd;
  logic [W-1:0] r_acc;
  logic         r_flag_c;

  logic         w_accept;
  logic         w_wb_acc;
  logic         w_wb_c;
  logic         w_illegal;

  assign w_illegal = (r_op > C_OP_PASS);

  // ---------------------------------------------------------------------------
  // State register and datapath registers. Reset has priority over everything,
  // so a command in flight is dropped without write-back and a command offered
  // in the reset cycle is not latched.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= C_OP_NOP;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_flag_c <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op   <= cmd_op;
        r_opnd <= cmd_data;
      end
      if (w_wb_acc) begin
        r_acc <= alu_f;
      end
      if (w_wb_c) begin
        r_flag_c <= alu_cout;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state, ULA drive and handshake outputs. The ULA sees a quiet
  // (a=acc, b=0, pass-a) configuration in every state except EXEC.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_wb_acc    = 1'b0;
    w_wb_c      = 1'b0;
    cmd_ready   = 1'b0;
    alu_b       = '0;
    alu_sub     = 1'b0;
    alu_sel     = C_SEL_A;
    res_valid   = 1'b0;
    err         = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        alu_b       = r_opnd;
        w_state_nxt = S_DONE;
        case (r_op)
          C_OP_LDA: begin
            alu_sel  = C_SEL_B;
            w_wb_acc = 1'b1;
          end
          C_OP_ADD: begin
            alu_sel  = C_SEL_SUM;
            w_wb_acc = 1'b1;
            w_wb_c   = 1'b1;
          end
          C_OP_SUB: begin
            alu_sel  = C_SEL_SUM;
            alu_sub  = 1'b1;
            w_wb_acc = 1'b1;
            w_wb_c   = 1'b1;
          end
          C_OP_PASS: begin
            alu_sel  = C_SEL_A;
            w_wb_acc = 1'b1;
          end
          default: begin
            // NOP and illegal opcodes leave acc and flag_c untouched.
            alu_sel = C_SEL_A;
          end
        endcase
      end

      S_DONE: begin
        res_valid   = 1'b1;
        err         = w_illegal;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign alu_a  = r_acc;
  assign acc    = r_acc;
  assign flag_c = r_flag_c;
  assign flag_n = r_acc[W-1];
  assign flag_z = (r_acc == '0);

endmodule
`default_nettype wire

// File: tb/tb_ula_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ula_seq_ctrl
// Purpose  : Directed self-checking bench for ula_seq_ctrl. A behavioural
//            ULA (adder/subtractor + output mux) closes the loop around the
//            sequencer; expected values are hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ula_seq_ctrl;

  localparam int W = 3;

  localparam logic [2:0] C_NOP  = 3'b000;
  localparam logic [2:0] C_LDA  = 3'b001;
  localparam logic [2:0] C_ADD  = 3'b010;
  localparam logic [2:0] C_SUB  = 3'b011;
  localparam logic [2:0] C_PASS = 3'b100;
  localparam logic [2:0] C_ILL  = 3'b110;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_sub;
  logic [1:0]   alu_sel;
  logic [W-1:0] alu_f;
  logic         alu_cout;
  logic [W-1:0] acc;
  logic         flag_c;
  logic         flag_n;
  logic         flag_z;
  logic         res_valid;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;

  ula_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sub   (alu_sub),
    .alu_sel   (alu_sel),
    .alu_f     (alu_f),
    .alu_cout  (alu_cout),
    .acc       (acc),
    .flag_c    (flag_c),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .res_valid (res_valid),
    .err       (err)
  );

  // Behavioural ULA: a + (b ^ sub) + sub, then 4:1 mux.
  logic [W:0] w_sum;
  always_comb begin
    w_sum    = {1'b0, alu_a} + {1'b0, (alu_sub ? ~alu_b : alu_b)} + {{W{1'b0}}, alu_sub};
    alu_cout = w_sum[W];
    case (alu_sel)
      2'b00:   alu_f = alu_a;
      2'b01:   alu_f = alu_b;
      2'b10:   alu_f = w_sum[W-1:0];
      default: alu_f = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command from IDLE and check EXEC drive, DONE result and the
  // return to IDLE. Inputs are scrambled during EXEC to prove they are latched.
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [W-1:0] d,
                         input logic [1:0] e_sel, input logic e_sub,
                         input logic [W-1:0] e_acc, input logic e_c, input logic e_err);
    check({tag, " ready"}, 8'(cmd_ready), 8'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    step();
    cmd_valid = 1'b0;
    cmd_op    = 3'b011;
    cmd_data  = ~d;
    check({tag, " exec ready"}, 8'(cmd_ready), 8'd0);
    check({tag, " exec sel"},   8'(alu_sel),   8'(e_sel));
    check({tag, " exec sub"},   8'(alu_sub),   8'(e_sub));
    check({tag, " exec b"},     8'(alu_b),     8'(d));
    check({tag, " exec rv"},    8'(res_valid), 8'd0);
    step();
    check({tag, " done rv"},  8'(res_valid), 8'd1);
    check({tag, " done err"}, 8'(err),       8'(e_err));
    check({tag, " done acc"}, 8'(acc),       8'(e_acc));
    check({tag, " done c"},   8'(flag_c),    8'(e_c));
    check({tag, " done n"},   8'(flag_n),    8'(e_acc[W-1]));
    check({tag, " done z"},   8'(flag_z),    8'(e_acc == '0));
    check({tag, " done b"},   8'(alu_b),     8'd0);
    step();
    check({tag, " idle rv"},  8'(res_valid), 8'd0);
    check({tag, " idle err"}, 8'(err),       8'd0);
    check({tag, " idle acc"}, 8'(acc),       8'(e_acc));
  endtask

  initial begin
    // Reset held together with a valid command: the command must not be taken.
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = C_LDA;
    cmd_data  = 3'd5;
    step();
    step();
    rst       = 1'b0;
    cmd_valid = 1'b0;

    // 1. Reset state and idle behaviour.
    check("rst acc",   8'(acc),       8'd0);
    check("rst z",     8'(flag_z),    8'd1);
    check("rst n",     8'(flag_n),    8'd0);
    check("rst c",     8'(flag_c),    8'd0);
    check("rst ready", 8'(cmd_ready), 8'd1);
    check("rst sel",   8'(alu_sel),   8'd0);
    check("rst sub",   8'(alu_sub),   8'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle rv",    8'(res_valid), 8'd0);
      check("idle ready", 8'(cmd_ready), 8'd1);
    end

    // 2..4. Arithmetic sequence.
    run_cmd("lda5",  C_LDA,  3'd5, 2'b01, 1'b0, 3'd5, 1'b0, 1'b0);
    run_cmd("add3",  C_ADD,  3'd3, 2'b10, 1'b0, 3'd0, 1'b1, 1'b0);
    run_cmd("lda2",  C_LDA,  3'd2, 2'b01, 1'b0, 3'd2, 1'b1, 1'b0);
    run_cmd("sub3",  C_SUB,  3'd3, 2'b10, 1'b1, 3'd7, 1'b0, 1'b0);
    run_cmd("sub7",  C_SUB,  3'd7, 2'b10, 1'b1, 3'd0, 1'b1, 1'b0);

    // 5. PASS, illegal opcode, NOP.
    run_cmd("lda4",  C_LDA,  3'd4, 2'b01, 1'b0, 3'd4, 1'b1, 1'b0);
    run_cmd("pass",  C_PASS, 3'd6, 2'b00, 1'b0, 3'd4, 1'b1, 1'b0);
    run_cmd("ill",   C_ILL,  3'd1, 2'b00, 1'b0, 3'd4, 1'b1, 1'b1);
    run_cmd("nop",   C_NOP,  3'd2, 2'b00, 1'b0, 3'd4, 1'b1, 1'b0);

    // 6. cmd_valid held high: accepts every third cycle, reset aborts LDA 3.
    cmd_valid = 1'b1;
    cmd_op    = C_LDA;
    cmd_data  = 3'd1;
    step();                                   // accept LDA 1
    cmd_data  = 3'd2;                         // offered while busy
    check("hold1 exec b",  8'(alu_b),     8'd1);
    check("hold1 ready",   8'(cmd_ready), 8'd0);
    step();
    check("hold1 done rv", 8'(res_valid), 8'd1);
    check("hold1 acc",     8'(acc),       8'd1);
    step();
    check("hold2 ready",   8'(cmd_ready), 8'd1);
    step();                                   // accept LDA 2
    cmd_data  = 3'd3;
    check("hold2 exec b",  8'(alu_b),     8'd2);
    step();
    check("hold2 acc",     8'(acc),       8'd2);
    check("hold2 rv",      8'(res_valid), 8'd1);
    step();
    check("hold3 ready",   8'(cmd_ready), 8'd1);
    step();                                   // accept LDA 3
    check("hold3 exec b",  8'(alu_b),     8'd3);
    check("hold3 exec sel",8'(alu_sel),   8'd1);
    rst       = 1'b1;
    cmd_data  = 3'd4;
    step();                                   // reset edge during EXEC
    rst       = 1'b0;
    check("abort rv",      8'(res_valid), 8'd0);
    check("abort acc",     8'(acc),       8'd0);
    check("abort c",       8'(flag_c),    8'd0);
    check("abort ready",   8'(cmd_ready), 8'd1);
    step();                                   // accept LDA 4
    check("hold4 exec b",  8'(alu_b),     8'd4);
    check("hold4 exec sel",8'(alu_sel),   8'd1);
    check("hold4 rv",      8'(res_valid), 8'd0);
    cmd_valid = 1'b0;
    step();
    check("hold4 done rv", 8'(res_valid), 8'd1);
    check("hold4 acc",     8'(acc),       8'd4);
    check("hold4 n",       8'(flag_n),    8'd1);
    step();
    check("hold4 idle rv", 8'(res_valid), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
